// File: rtl/adder_result_fifo.sv
`default_nettype none
// =============================================================================
// Module      : adder_result_fifo
// Description : First-word-fall-through buffer for the pipelined adder output,
//               with sticky overflow status and a saturating drop counter.
//               Optional statistics ports enabled by RESULT_FIFO_STATS_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module adder_result_fifo #(
   parameter int DEPTH     = 8,
   parameter int DATA_W    = 32,
   parameter int AFULL_LVL = 6,
   parameter int DROP_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_result,
   input  logic                       in_carry,
   input  logic                       in_overflow,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_result,
   output logic                       out_carry,
   output logic                       out_overflow,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       sticky_ovf,
   output logic [DROP_W-1:0]          drop_count,
   input  logic                       clear_status
`ifdef RESULT_FIFO_STATS_EN
   ,
   output logic [15:0]                pop_count,
   output logic [$clog2(DEPTH+1)-1:0] peak_level
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_AFULL = CNT_W'(AFULL_LVL);

   logic [DATA_W-1:0] r_mem_data  [DEPTH];
   logic              r_mem_carry [DEPTH];
   logic              r_mem_ovf   [DEPTH];

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_fill;
   logic [CNT_W-1:0]  w_fill_next;
   logic              r_sticky;
   logic [DROP_W-1:0] r_drop;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_full  = (r_fill == c_DEPTH);
   assign w_empty = (r_fill == '0);
   assign w_pop   = !w_empty && out_ready;
   // A full FIFO can still take a beat when the head leaves in the same cycle.
   assign w_push  = in_valid && (!w_full || w_pop);
   assign w_drop  = in_valid && w_full && !w_pop;

   always_comb begin
      w_fill_next = r_fill;
      case ({w_push, w_pop})
         2'b10:   w_fill_next = r_fill + CNT_W'(1);
         2'b01:   w_fill_next = r_fill - CNT_W'(1);
         default: w_fill_next = r_fill;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr]  <= in_result;
         r_mem_carry[r_wr_ptr] <= in_carry;
         r_mem_ovf[r_wr_ptr]   <= in_overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_fill <= w_fill_next;
      end
   end

   // clear_status takes priority over a same-cycle set or increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
         r_drop   <= '0;
      end else if (clear_status) begin
         r_sticky <= 1'b0;
         r_drop   <= '0;
      end else begin
         if (w_push && in_overflow) r_sticky <= 1'b1;
         if (w_drop && (r_drop != {DROP_W{1'b1}})) r_drop <= r_drop + DROP_W'(1);
      end
   end

`ifdef RESULT_FIFO_STATS_EN
   logic [15:0]      r_pop_count;
   logic [CNT_W-1:0] r_peak;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pop_count <= '0;
         r_peak      <= '0;
      end else if (clear_status) begin
         r_pop_count <= '0;
         r_peak      <= w_fill_next;
      end else begin
         if (w_pop) r_pop_count <= r_pop_count + 16'd1;
         if (w_fill_next > r_peak) r_peak <= w_fill_next;
      end
   end

   assign pop_count  = r_pop_count;
   assign peak_level = r_peak;
`endif

   assign out_valid    = !w_empty;
   assign out_result   = w_empty ? '0   : r_mem_data[r_rd_ptr];
   assign out_carry    = w_empty ? 1'b0 : r_mem_carry[r_rd_ptr];
   assign out_overflow = w_empty ? 1'b0 : r_mem_ovf[r_rd_ptr];
   assign fill_level   = r_fill;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_fill >= c_AFULL);
   assign sticky_ovf   = r_sticky;
   assign drop_count   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_fifo.sv
`default_nettype none
// =============================================================================
// Module      : tb_adder_result_fifo
// Description : Directed, table-driven self-checking bench for adder_result_fifo.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_adder_result_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_result;
   logic        in_carry;
   logic        in_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_carry;
   logic        out_overflow;
   logic [3:0]  fill_level;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic        sticky_ovf;
   logic [7:0]  drop_count;
   logic        clear_status;
`ifdef RESULT_FIFO_STATS_EN
   logic [15:0] pop_count;
   logic [3:0]  peak_level;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   adder_result_fifo dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_result    (in_result),
      .in_carry     (in_carry),
      .in_overflow  (in_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .fill_level   (fill_level),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .sticky_ovf   (sticky_ovf),
      .drop_count   (drop_count),
      .clear_status (clear_status)
`ifdef RESULT_FIFO_STATS_EN
      ,
      .pop_count    (pop_count),
      .peak_level   (peak_level)
`endif
   );

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        c;
      logic        o;
      logic        rdy;
      logic        clr;
      logic        ev;
      logic [31:0] er;
      logic        ec;
      logic        eo;
      logic [3:0]  ef;
      logic        es;
   } vec_t;

   vec_t vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, then settle past the edge.
   task automatic step(input logic iv, input logic [31:0] d, input logic c,
                       input logic o, input logic rdy, input logic clr);
      in_valid     = iv;
      in_result    = d;
      in_carry     = c;
      in_overflow  = o;
      out_ready    = rdy;
      clear_status = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      vec[0] = '{1, 32'h1234, 0, 0, 0, 0,  1, 32'h1234, 0, 0, 4'd1, 0};
      vec[1] = '{0, 32'h0,    0, 0, 0, 0,  1, 32'h1234, 0, 0, 4'd1, 0};
      vec[2] = '{1, 32'h5678, 1, 1, 0, 0,  1, 32'h1234, 0, 0, 4'd2, 1};
      vec[3] = '{1, 32'h9,    0, 0, 1, 0,  1, 32'h5678, 1, 1, 4'd2, 1};
      vec[4] = '{0, 32'h0,    0, 0, 1, 1,  1, 32'h9,    0, 0, 4'd1, 0};
      vec[5] = '{1, 32'hA,    0, 1, 0, 1,  1, 32'h9,    0, 0, 4'd2, 0};
      vec[6] = '{0, 32'h0,    0, 0, 1, 0,  1, 32'hA,    0, 1, 4'd1, 0};
      vec[7] = '{0, 32'h0,    0, 0, 1, 0,  0, 32'h0,    0, 0, 4'd0, 0};
      vec[8] = '{1, 32'hB,    0, 0, 1, 0,  1, 32'hB,    0, 0, 4'd1, 0};
      vec[9] = '{0, 32'h0,    0, 0, 1, 0,  0, 32'h0,    0, 0, 4'd0, 0};

      rst_n = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_sticky", sticky_ovf, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_result", out_result, 0);

      // Single beat, held at the head while the consumer stalls.
      step(1, 32'h0000_1234, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_result", out_result, 32'h1234);
         chk("hold_fill", fill_level, 1);
         chk("hold_empty", empty, 0);
         step(0, 0, 0, 0, 0, 0);
      end

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(vec[i].iv, vec[i].d, vec[i].c, vec[i].o, vec[i].rdy, vec[i].clr);
         chk($sformatf("vec%0d_valid", i),  out_valid,    vec[i].ev);
         chk($sformatf("vec%0d_result", i), out_result,   vec[i].er);
         chk($sformatf("vec%0d_carry", i),  out_carry,    vec[i].ec);
         chk($sformatf("vec%0d_ovf", i),    out_overflow, vec[i].eo);
         chk($sformatf("vec%0d_fill", i),   fill_level,   vec[i].ef);
         chk($sformatf("vec%0d_sticky", i), sticky_ovf,   vec[i].es);
      end

      // Fill to full, overrun once, then push+pop while full.
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         step(1, i, 0, 0, 0, 0);
         chk($sformatf("fill%0d_level", i), fill_level, i);
         chk($sformatf("fill%0d_afull", i), almost_full, (i >= 6));
         chk($sformatf("fill%0d_full", i), full, (i == 8));
      end
      step(1, 9, 0, 1, 0, 0);
      chk("ovr_drop", drop_count, 1);
      chk("ovr_fill", fill_level, 8);
      chk("ovr_sticky", sticky_ovf, 0);
      chk("ovr_head", out_result, 1);
      step(1, 32'hAA, 0, 0, 1, 0);
      chk("fullpp_fill", fill_level, 8);
      chk("fullpp_drop", drop_count, 1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d_valid", i), out_valid, 1);
         chk($sformatf("drain%0d_data", i), out_result, (i == 7) ? 32'hAA : 32'(i + 2));
         step(0, 0, 0, 0, 1, 0);
      end
      chk("drain_empty", empty, 1);
      chk("drain_result0", out_result, 0);

      // Saturating drop counter and clear priority.
      step(0, 0, 0, 0, 0, 1);
      chk("clr_drop", drop_count, 0);
      for (int i = 0; i < 8; i++) step(1, 32'h100 + i, 0, 0, 0, 0);
      step(1, 32'hDEAD, 0, 1, 0, 1);
      chk("clr_vs_drop", drop_count, 0);
      for (int i = 0; i < 300; i++) step(1, 32'hBEEF, 0, 1, 0, 0);
      chk("sat_drop", drop_count, 255);
      chk("sat_sticky", sticky_ovf, 0);
      chk("sat_fill", fill_level, 8);
      step(0, 0, 0, 0, 0, 1);
      chk("sat_clear", drop_count, 0);

      // Reset with 5 entries stored discards them.
      step(1, 32'h77, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
      chk("pre_rst_fill", fill_level, 5);
      chk("pre_rst_drop", drop_count, 1);
      do_reset();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_fill", fill_level, 0);
      chk("mid_rst_drop", drop_count, 0);
      step(1, 32'h55, 0, 0, 0, 0);
      chk("post_rst_head", out_result, 32'h55);
      step(0, 0, 0, 0, 1, 0);
      chk("post_rst_empty", empty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adder_result_fifo.md
Name: adder_result_fifo

Overview:
- Output-side buffer placed directly downstream of the 32-bit pipelined adder.
- Captures each result beat (result, carry, overflow) qualified by the adder's valid_out. The adder cannot be stalled.
- Presents the beats to the consumer over a valid/ready handshake.
- Tracks sticky error status and counts beats dropped on overrun.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- DATA_W, 32, result width.
- AFULL_LVL, 6, fill level at or above which almost_full asserts; 1..DEPTH.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  beat present (from adder valid_out).
- in_result  in  DATA_W  result word.
- in_carry  in  1  carry flag of the beat.
- in_overflow  in  1  overflow flag of the beat.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_result  out  DATA_W  head result.
- out_carry  out  1  head carry.
- out_overflow  out  1  head overflow.
- fill_level  out  $clog2(DEPTH+1)  number of occupied entries.
- full  out  1  fill_level == DEPTH.
- empty  out  1  fill_level == 0.
- almost_full  out  1  fill_level >= AFULL_LVL.
- sticky_ovf  out  1  set when any accepted beat has overflow=1.
- drop_count  out  DROP_W  number of beats lost to overrun; saturates.
- clear_status  in  1  clears sticky_ovf and drop_count.

Behaviour:
- Reset (rst_n low at a clk edge): rd/wr pointers=0, fill_level=0, empty=1, full=0, almost_full=0, out_valid=0, sticky_ovf=0, drop_count=0. out_result/out_carry/out_overflow are 0 while empty. Reset mid-operation discards all contents without emitting them.
- pop = out_valid & out_ready.
- push = in_valid & (!full | pop). A full FIFO with a same-cycle pop accepts the new beat; fill_level stays DEPTH.
- drop = in_valid & full & !pop. Beat discarded; drop_count += 1, saturating at 2^DROP_W-1. No wrap.
- First-word-fall-through:
  - Beat pushed at edge N into an empty FIFO gives out_valid=1 with its data after edge N. Latency 1 cycle.
  - Out fields are driven from the head entry; they are stable while out_valid & !out_ready.
- Push and pop in the same cycle when not empty: fill_level unchanged, both pointers advance.
- Push and pop on an empty FIFO: push only. Pop is impossible because out_valid=0; no bypass.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- sticky_ovf:
  - Set on an accepted push with in_overflow=1.
  - Dropped beats do not set it.
  - clear_status has priority over a same-cycle set; the flag reads 0 the next cycle.
- clear_status and drop in the same cycle: drop_count=0, i.e. clear wins.
- Status flags are all registered or derived from the registered fill_level; no comb path from in_valid.
- The only combinational input→output path is none for data. out_valid does not depend on out_ready.

Optional Feature:
- Macro RESULT_FIFO_STATS_EN.
- When defined:
  - Adds output port pop_count [15:0], incremented on every pop and wrapping modulo 2^16.
  - Reset to 0; cleared by clear_status with priority over a same-cycle increment.
  - Adds output port peak_level ($clog2(DEPTH+1) bits), holding the max fill_level seen since reset/clear_status.
- When undefined: neither port exists, and all other behaviour is identical.

Test Plan:
- Reset, then one beat in_result=0x0000_1234, carry=0, ovf=0, out_ready=0 -> next cycle out_valid=1, out_result=0x1234, fill_level=1, empty=0; held stable for 5 cycles.
- 8 consecutive beats 1..8, out_ready=0 -> full=1, almost_full asserted after 6th beat; 9th beat value 9 -> drop_count=1, and popping returns 1..8 in order.
- Full FIFO, out_ready=1 and in_valid=1 (value 0xAA) same cycle -> no drop, fill_level stays 8, 0xAA emerges as the 8th pop after.
- Beat with in_overflow=1 -> sticky_ovf=1 next cycle; clear_status pulse coincident with a second overflow beat -> sticky_ovf=0.
- 300 overrun beats while full -> drop_count=255 (saturated); clear_status -> 0.
- rst_n low for one edge with 5 entries stored -> out_valid=0, fill_level=0, drop_count=0; a subsequent beat 0x55 is the first word popped.
